// File: rtl/bsg_level_shift_seq_pkg.sv
// Shared types and helpers for the level-shifter enable sequencer.
package bsg_level_shift_seq_pkg;

  localparam int unsigned state_width_lp = 3;

  typedef enum logic [state_width_lp-1:0] {
    eOff, ePwrUp, eSettle, eOn, eDrain, ePwrDn
  } state_e;

  typedef struct packed {
    logic req;
    logic en;
    logic busy;
  } seq_outs_s;

  function automatic int unsigned safe_clog2(input int unsigned x);
    return (x <= 32'd1) ? 32'd1 : 32'($clog2(x));
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Output levels owned by each state; registered alongside the state itself.
  function automatic seq_outs_s outs_of(input state_e s);
    seq_outs_s o;
    o = '0;
    unique case (s)
      ePwrUp, eSettle, eDrain: begin
        o.req  = 1'b1;
        o.busy = 1'b1;
      end
      eOn: begin
        o.req = 1'b1;
        o.en  = 1'b1;
      end
      ePwrDn:  o.busy = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/bsg_level_shift_seq_delay_ctr.sv
// Loadable down-counter that saturates at zero; zero_o flags the expired count.
module bsg_level_shift_seq_delay_ctr
  import bsg_level_shift_seq_pkg::*;
#(
  parameter  int unsigned max_val_p = 16,
  localparam int unsigned width_lp  = safe_clog2(max_val_p)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                load_i,
  input  logic [width_lp-1:0] load_val_i,
  input  logic                dec_i,
  output logic                zero_o
);

  logic [width_lp-1:0] count_r;

  always_ff @(posedge clk_i) begin
    if (reset_i)
      count_r <= '0;
    else if (load_i)
      count_r <= load_val_i;
    else if (dec_i && (count_r != '0))
      count_r <= count_r - width_lp'(1);
  end

  assign zero_o = (count_r == '0);

endmodule

// File: rtl/bsg_level_shift_en_sequencer.sv
// Power-up/down sequencer for a switchable domain's level-shifter enable.
// Define BSG_LEVEL_SHIFT_SEQ_TIMEOUT_EN to add the sticky power-ack timeout.
module bsg_level_shift_en_sequencer
  import bsg_level_shift_seq_pkg::*;
#(
  parameter int unsigned settle_cycles_p  = 16,
  parameter int unsigned drain_cycles_p   = 4,
  parameter int unsigned timeout_cycles_p = 1024
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic on_req_i,
  input  logic pwr_ack_i,
  output logic pwr_req_o,
  output logic ls_en_o,
  output logic ready_o,
  output logic busy_o,
  output logic error_o
);

  localparam int unsigned dly_width_lp = safe_clog2(max_u(settle_cycles_p, drain_cycles_p));
  localparam logic [dly_width_lp-1:0] settle_load_lp = dly_width_lp'(settle_cycles_p - 1);
  localparam logic [dly_width_lp-1:0] drain_load_lp  = dly_width_lp'(drain_cycles_p - 1);

`ifdef BSG_LEVEL_SHIFT_SEQ_TIMEOUT_EN
  localparam logic tmo_en_lp = 1'b1;
`else
  localparam logic tmo_en_lp = 1'b0;
`endif

  state_e    state_r;
  seq_outs_s outs_r;
  logic      error_r;
  logic      go_settle, go_drain, dly_load, dly_zero, tmo_zero;

  // Delay counter is shared: settle interval on the way up, drain on the way down.
  assign go_settle = (state_r == ePwrUp) && on_req_i && pwr_ack_i;
  assign go_drain  = (state_r == eOn) && !on_req_i;
  assign dly_load  = go_settle | go_drain;

  bsg_level_shift_seq_delay_ctr #(
    .max_val_p(max_u(settle_cycles_p, drain_cycles_p))
  ) u_dly (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .load_i    (dly_load),
    .load_val_i(go_settle ? settle_load_lp : drain_load_lp),
    .dec_i     (!dly_load),
    .zero_o    (dly_zero)
  );

`ifdef BSG_LEVEL_SHIFT_SEQ_TIMEOUT_EN
  localparam int unsigned tmo_width_lp = safe_clog2(timeout_cycles_p);
  logic tmo_load;

  // Reload outside the ack-wait states and when hopping straight from PWR_UP to PWR_DN.
  assign tmo_load = !((state_r == ePwrUp) || (state_r == ePwrDn))
                  || ((state_r == ePwrUp) && !on_req_i);

  bsg_level_shift_seq_delay_ctr #(
    .max_val_p(timeout_cycles_p)
  ) u_tmo (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .load_i    (tmo_load),
    .load_val_i(tmo_width_lp'(timeout_cycles_p - 1)),
    .dec_i     (!tmo_load),
    .zero_o    (tmo_zero)
  );
`else
  logic unused_tmo;
  assign tmo_zero   = 1'b0;
  assign unused_tmo = ^timeout_cycles_p;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= eOff;
      outs_r  <= '0;
      error_r <= 1'b0;
    end else begin
      unique case (state_r)
        eOff: if (on_req_i && !error_r) begin
          state_r <= ePwrUp;  outs_r <= outs_of(ePwrUp);
        end
        ePwrUp: if (!on_req_i) begin
          state_r <= ePwrDn;  outs_r <= outs_of(ePwrDn);
        end else if (pwr_ack_i) begin
          state_r <= eSettle; outs_r <= outs_of(eSettle);
        end else if (tmo_zero) begin
          state_r <= eOff;    outs_r <= outs_of(eOff);  error_r <= 1'b1;
        end
        eSettle: if (!on_req_i) begin
          state_r <= ePwrDn;  outs_r <= outs_of(ePwrDn);
        end else if (!pwr_ack_i) begin
          state_r <= ePwrUp;  outs_r <= outs_of(ePwrUp);
        end else if (dly_zero) begin
          state_r <= eOn;     outs_r <= outs_of(eOn);
        end
        eOn: if (tmo_en_lp && !pwr_ack_i) begin
          state_r <= eOff;    outs_r <= outs_of(eOff);  error_r <= 1'b1;
        end else if (!on_req_i) begin
          state_r <= eDrain;  outs_r <= outs_of(eDrain);
        end
        eDrain: if (dly_zero) begin
          state_r <= ePwrDn;  outs_r <= outs_of(ePwrDn);
        end
        ePwrDn: if (!pwr_ack_i) begin
          state_r <= eOff;    outs_r <= outs_of(eOff);
        end else if (tmo_zero) begin
          state_r <= eOff;    outs_r <= outs_of(eOff);  error_r <= 1'b1;
        end
        default: begin
          state_r <= eOff;    outs_r <= outs_of(eOff);
        end
      endcase
    end
  end

  assign pwr_req_o = outs_r.req;
  assign ls_en_o   = outs_r.en;
  assign ready_o   = outs_r.en;
  assign busy_o    = outs_r.busy;
  assign error_o   = error_r;

endmodule

// File: tb/tb_bsg_level_shift_en_sequencer.sv
// Directed bench for bsg_level_shift_en_sequencer with a cycle-level reference model.
module tb_bsg_level_shift_en_sequencer;

  localparam int settle_lp  = 16;
  localparam int drain_lp   = 4;
  localparam int timeout_lp = 8;

  logic clk = 1'b0;
  logic reset, on_req, ack;
  logic pwr_req, ls_en, ready, busy, error;

  always #5 clk = ~clk;

  bsg_level_shift_en_sequencer #(
    .settle_cycles_p (settle_lp),
    .drain_cycles_p  (drain_lp),
    .timeout_cycles_p(timeout_lp)
  ) dut (
    .clk_i    (clk),
    .reset_i  (reset),
    .on_req_i (on_req),
    .pwr_ack_i(ack),
    .pwr_req_o(pwr_req),
    .ls_en_o  (ls_en),
    .ready_o  (ready),
    .busy_o   (busy),
    .error_o  (error)
  );

  int checks = 0;
  int errors = 0;
  bit model_en = 1'b1;

  // Reference: request/enable levels derived from ack run length and drain countdown.
  bit m_req = 0, m_en = 0, m_busy = 0;
  int ack_run = 0, drain_left = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_req = 0; m_en = 0; m_busy = 0; ack_run = 0; drain_left = 0;
    end else if (m_en) begin
      if (!on_req) begin m_en = 0; m_busy = 1; drain_left = drain_lp; end
    end else if (drain_left > 0) begin
      drain_left--;
      if (drain_left == 0) m_req = 0;
    end else if (!m_req && m_busy) begin
      if (!ack) m_busy = 0;
    end else if (!m_req) begin
      if (on_req) begin m_req = 1; m_busy = 1; ack_run = 0; end
    end else if (!on_req) begin
      m_req = 0; ack_run = 0;
    end else if (ack) begin
      ack_run++;
      if (ack_run == settle_lp + 1) begin m_en = 1; m_busy = 0; end
    end else begin
      ack_run = 0;
    end
  end

  always @(negedge clk) begin
    if (model_en) begin
      checks++;
      if ({pwr_req, ls_en, ready, busy, error} !== {m_req, m_en, m_en, m_busy, 1'b0}) begin
        errors++;
        $display("FAIL model_cmp t=%0t actual req/en/rdy/busy/err=%b required=%b", $time,
                 {pwr_req, ls_en, ready, busy, error}, {m_req, m_en, m_en, m_busy, 1'b0});
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int n;

  initial begin
    reset = 1'b1; on_req = 1'b0; ack = 1'b0;
    step(2);
    check("reset_outs", int'({pwr_req, ls_en, ready, busy, error}), 0);
    reset = 1'b0;

    // Power-up with ack returned 3 cycles after request.
    on_req = 1'b1;
    step(1);
    check("t1_req_rise", int'(pwr_req), 1);
    step(3);
    ack = 1'b1;
    n = 0;
    do begin step(1); n++; end while (!ls_en && n < 100);
    check("t1_en_after_ack", n, 17);
    check("t1_ready", int'(ready), 1);

    // Drop request while on: enable falls, drain, then release.
    on_req = 1'b0;
    step(1);
    check("t2_en_fall", int'(ls_en), 0);
    check("t2_req_held", int'(pwr_req), 1);
    n = 0;
    do begin step(1); n++; end while (pwr_req && n < 100);
    check("t2_drain_len", n, drain_lp);
    ack = 1'b0;
    step(1);
    check("t2_off_busy", int'(busy), 0);

    // Abort during the 5th settle cycle.
    on_req = 1'b1;
    step(1);
    ack = 1'b1;
    step(1);
    step(4);
    on_req = 1'b0;
    step(1);
    check("t3_req_fall", int'(pwr_req), 0);
    check("t3_no_en", int'(ls_en), 0);
    ack = 1'b0;
    step(2);

    // One-cycle ack glitch mid-settle restarts the full settle interval.
    on_req = 1'b1;
    step(1);
    ack = 1'b1;
    step(6);
    ack = 1'b0;
    step(1);
    check("t4_back_pwrup", int'({pwr_req, busy}), 3);
    ack = 1'b1;
    n = 0;
    do begin step(1); n++; end while (!ls_en && n < 100);
    check("t4_resettle", n, 17);

    // Emergency reset inside drain, then minimum-latency power-up.
    on_req = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
    check("t5_reset_outs", int'({pwr_req, ls_en, ready, busy, error}), 0);
    reset = 1'b0;
    on_req = 1'b1;
    n = 0;
    do begin step(1); n++; end while (!ls_en && n < 100);
    check("t5_min_latency", n, 2 + settle_lp);

    on_req = 1'b0;
    step(1 + drain_lp);
    ack = 1'b0;
    step(2);
    check("idle_error", int'(error), 0);
    check("idle_busy", int'(busy), 0);

`ifdef BSG_LEVEL_SHIFT_SEQ_TIMEOUT_EN
    // Ack never arrives: error after timeout_lp PWR_UP cycles, then request ignored.
    model_en = 1'b0;
    on_req = 1'b1;
    step(1);
    step(timeout_lp - 1);
    check("tmo_not_yet", int'(error), 0);
    step(1);
    check("tmo_error", int'(error), 1);
    check("tmo_req_off", int'(pwr_req), 0);
    step(3);
    check("tmo_ignored", int'({pwr_req, busy, error}), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
